// File: rtl/pwm_level_scheduler.sv
`timescale 1ns/1ps
// pwm_level_scheduler: LED brightness level control (manual steps or auto breathing sweep)
// with a PWM period counter; duty changes are committed only at period boundaries.
module pwm_level_scheduler #(
  parameter int unsigned PERIOD       = 1_000_000,
  parameter int unsigned NUM_LEVELS   = 5,
  parameter int unsigned STEP_PERIODS = 50,
  parameter int unsigned RESET_LEVEL  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_up,
  input  logic       cmd_down,
  input  logic       cmd_auto,
  input  logic [3:0] led_in,
  output logic [3:0] led_out,
  output logic [2:0] level,
  output logic       auto_active,
  output logic       period_start
);

  localparam int unsigned   CW        = $clog2(PERIOD);
  localparam int unsigned   SW        = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [2:0]    LVL_MAX   = 3'(NUM_LEVELS - 1);
  localparam logic [2:0]    LVL_RST   = 3'(RESET_LEVEL);

  typedef enum logic [1:0] {
    MANUAL,
    AUTO_UP,
    AUTO_DOWN
  } state_t;

  function automatic logic [CW:0] duty_of(input logic [2:0] lvl);
    logic [31:0] d;
    if (lvl == 3'd0) d = PERIOD / 20;
    else             d = (32'(lvl) * PERIOD) / (NUM_LEVELS - 1);
    return (CW + 1)'(d);
  endfunction

  logic [CW-1:0] cnt;
  logic [CW:0]   duty_act;
  logic          cnt_wrap;

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    level_d;
  logic [SW-1:0] step_q;
  logic [SW-1:0] step_d;

  assign cnt_wrap    = (cnt == CNT_LAST);
  assign auto_active = (state_q != MANUAL);

  // PWM datapath: duty_act samples the committed level only on the wrap edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      duty_act     <= duty_of(LVL_RST);
      led_out      <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_wrap ? '0 : cnt + 1'b1;
      period_start <= cnt_wrap;
      if (cnt_wrap) duty_act <= duty_of(level);
      led_out      <= ({1'b0, cnt} < duty_act) ? led_in : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MANUAL;
      level   <= LVL_RST;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      level   <= level_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level;
    step_d  = step_q;
    unique case (state_q)
      MANUAL: begin
        if (cmd_auto) begin
          state_d = (level == LVL_MAX) ? AUTO_DOWN : AUTO_UP;
          step_d  = '0;
        end else if (cmd_up) begin
          if (level != LVL_MAX) level_d = level + 3'd1;
        end else if (cmd_down) begin
          if (level != 3'd0) level_d = level - 3'd1;
        end
      end
      AUTO_UP: begin
        if (cmd_auto) begin
          state_d = MANUAL;
          step_d  = '0;
        end else if (period_start) begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            if (level != LVL_MAX) level_d = level + 3'd1;
            if (level_d == LVL_MAX) state_d = AUTO_DOWN;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      AUTO_DOWN: begin
        if (cmd_auto) begin
          state_d = MANUAL;
          step_d  = '0;
        end else if (period_start) begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            if (level != 3'd0) level_d = level - 3'd1;
            if (level_d == 3'd0) state_d = AUTO_UP;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: state_d = MANUAL;
    endcase
  end

endmodule
